apb4_master_mux: RTL and testbench

Parametrised APB4 master that succeeds the single-slave APB3 master. It accepts requests on a valid/ready front end and drives an APB4 bus, with PSTRB and PPROT, to NUM_SLV slaves through an integrated address decoder. It returns one registered response per request. It sits between the system-side request fabric and the peripheral slaves, and supports back-to-back transfers and decode-error reporting.

---
 rtl/apb4_master_mux_if.sv | 61 ++++++
 rtl/apb4_master_mux.sv | 202 ++++++++++++++++++++
 tb/tb_apb4_master_mux.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_master_mux_if.sv
// ---------------------------------------------------------------------------
// apb4_master_mux_if
// Bundles the request/response front end and the APB4 bus of apb4_master_mux.
//
// Signals:
//   req_valid/req_ready   request handshake (accepted when both are 1)
//   req_write/addr/wdata/strb/prot   request attributes
//   rsp_valid/rsp_rdata/rsp_err      single-cycle registered response
//   PSEL[NUM_SLV] PENABLE PWRITE PADDR PWDATA PSTRB PPROT   APB4 master outputs
//   PRDATA[NUM_SLV*DATA_WIDTH] PREADY[NUM_SLV] PSLVERR[NUM_SLV]  per-slave inputs
//
// Modports:
//   master : the APB4 master (drives req_ready, rsp_*, P* outputs)
//   slave  : the environment side (system requester + peripheral slaves)
// ---------------------------------------------------------------------------
interface apb4_master_mux_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLV    = 4
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                          req_valid;
  logic                          req_ready;
  logic                          req_write;
  logic [ADDR_WIDTH-1:0]         req_addr;
  logic [DATA_WIDTH-1:0]         req_wdata;
  logic [STRB_WIDTH-1:0]         req_strb;
  logic [2:0]                    req_prot;

  logic                          rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;

  logic [NUM_SLV-1:0]            PSEL;
  logic                          PENABLE;
  logic                          PWRITE;
  logic [ADDR_WIDTH-1:0]         PADDR;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic [STRB_WIDTH-1:0]         PSTRB;
  logic [2:0]                    PPROT;
  logic [NUM_SLV*DATA_WIDTH-1:0] PRDATA;
  logic [NUM_SLV-1:0]            PREADY;
  logic [NUM_SLV-1:0]            PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_master_mux.sv
// ---------------------------------------------------------------------------
// apb4_master_mux
// APB4 master with an integrated address decoder for NUM_SLV slaves. Takes
// requests on a valid/ready front end, runs one SETUP/ACCESS transfer per
// request and returns one registered response pulse per request. Requests
// whose slave region is outside 0..NUM_SLV-1 get a decode-error response
// without touching the bus.
//
// Ports:
//   PCLK     in   bus clock, rising edge
//   PRESETn  in   asynchronous active-low reset
//   bus      apb4_master_mux_if.master (request, response and APB4 signals)
//
// Optional feature (compile-time macro APB_TIMEOUT_EN):
//   defined   : ACCESS is aborted with an error response after TIMEOUT_CYC
//               consecutive wait cycles of the selected slave
//   undefined : ACCESS waits for PREADY indefinitely
// ---------------------------------------------------------------------------
module apb4_master_mux #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_SLV      = 4,
  parameter int unsigned SLV_WIN_BITS = 12,
  parameter int unsigned TIMEOUT_CYC  = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb4_master_mux_if.master bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SEL_W      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_dw
    $error("apb4_master_mux: DATA_WIDTH must be 8, 16 or 32");
  end
  if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_ns
    $error("apb4_master_mux: NUM_SLV must be 1..16");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_to
    $error("apb4_master_mux: TIMEOUT_CYC must be 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DECERR
  } state_t;

  state_t                r_state;
  logic [SEL_W-1:0]      r_idx;
  logic [NUM_SLV-1:0]    r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [STRB_WIDTH-1:0] r_pstrb;
  logic [2:0]            r_pprot;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0]            r_wait;
`endif

  logic                  w_sel_ready;
  logic                  w_sel_err;
  logic [DATA_WIDTH-1:0] w_sel_rdata;
  logic [SEL_W-1:0]      w_dec_idx;
  logic                  w_dec_ok;
  logic [NUM_SLV-1:0]    w_dec_onehot;
  logic                  w_done;
  logic                  w_req_ready;
  logic                  w_accept;

  // Slave index is the SEL_W field above the window; the whole upper address
  // is range-checked so that aliases beyond the last slave decode as errors.
  assign w_dec_idx = bus.req_addr[SLV_WIN_BITS +: SEL_W];
  assign w_dec_ok  = ((bus.req_addr >> SLV_WIN_BITS) < ADDR_WIDTH'(NUM_SLV));

  always_comb begin
    w_dec_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (w_dec_idx == SEL_W'(i)) w_dec_onehot[i] = 1'b1;
    end
  end

  // Response mux from the slave latched at launch; other slaves are ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (r_idx == SEL_W'(i)) begin
        w_sel_ready = bus.PREADY[i];
        w_sel_err   = bus.PSLVERR[i];
        w_sel_rdata = bus.PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_done      = (r_state == S_ACCESS) && w_sel_ready;
  assign w_req_ready = PRESETn && ((r_state == S_IDLE) || w_done);
  assign w_accept    = bus.req_valid && w_req_ready;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_wait      <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
          r_wait    <= '0;
`endif
        end
        S_ACCESS: begin
          if (w_sel_ready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_sel_err;
            if (!r_pwrite) r_rsp_rdata <= w_sel_rdata;
            r_penable   <= 1'b0;
            r_psel      <= '0;
            r_state     <= S_IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (r_wait == TO_LAST) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_penable   <= 1'b0;
            r_psel      <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
`endif
        end
        S_DECERR: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A launch overrides the IDLE fall-back above, which is what gives the
      // back-to-back path out of a completing ACCESS.
      if (w_accept) begin
        if (w_dec_ok) begin
          r_state  <= S_SETUP;
          r_idx    <= w_dec_idx;
          r_psel   <= w_dec_onehot;
          r_paddr  <= bus.req_addr;
          r_pwrite <= bus.req_write;
          r_pwdata <= bus.req_wdata;
          r_pstrb  <= bus.req_write ? bus.req_strb : '0;
          r_pprot  <= bus.req_prot;
        end else begin
          r_state  <= S_DECERR;
          r_psel   <= '0;
        end
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PSTRB     = r_pstrb;
  assign bus.PPROT     = r_pprot;

endmodule

// File: tb/tb_apb4_master_mux.sv
// ---------------------------------------------------------------------------
// tb_apb4_master_mux
// Drives directed then random requests into apb4_master_mux, plays the APB4
// slaves with chosen wait states, data and errors, and predicts the bus
// activity and responses from a transaction-level timeline model.
// ---------------------------------------------------------------------------
module tb_apb4_master_mux;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned NS    = 4;
  localparam int unsigned SB    = DW / 8;
  localparam int unsigned WIN   = 12;
  localparam int unsigned NR    = 80;
  localparam int          LIMIT = 4000;
  localparam int unsigned ND    = 6;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [SB-1:0] strb;
    logic [2:0]    prot;
    int unsigned   waits;
    logic          err;
  } txn_t;

  typedef struct {
    int            cyc;
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  apb4_master_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLV(NS)) bus ();

  apb4_master_mux #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_SLV     (NS),
    .SLV_WIN_BITS(WIN),
    .TIMEOUT_CYC (16)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus.master)
  );

  always #5 PCLK = ~PCLK;

  txn_t          dirs [ND];
  txn_t          nxt, cur;
  rsp_t          rq [$];
  int unsigned   cur_idx;
  logic          win_on;
  int            win_setup, win_done, free_at;
  logic [NS-1:0] win_sel;
  logic [AW-1:0] e_paddr;
  logic          e_pwrite;
  logic [DW-1:0] e_pwdata;
  logic [SB-1:0] e_pstrb;
  logic [2:0]    e_pprot;
  logic [DW-1:0] last_rd, shown_rd;
  bit            pend;
  int            dir_i, n_rand, cyc;
  bit            fin;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    if ($urandom_range(9) == 0) t.addr = $urandom;
    else t.addr = ($urandom_range(5) << WIN) | $urandom_range(4095);
    t.wr    = 1'($urandom_range(1));
    t.wdata = $urandom;
    t.rdata = $urandom;
    t.strb  = SB'($urandom);
    t.prot  = 3'($urandom);
    t.waits = $urandom_range(3);
    t.err   = ($urandom_range(3) == 0);
    return t;
  endfunction

  // Bus and response expectations for the cycle now visible on the outputs.
  task automatic check_cycle(input int c);
    logic in_win;
    in_win = win_on && (c >= win_setup) && (c <= win_done);
    chk("psel",    bus.PSEL,    in_win ? win_sel : '0);
    chk("penable", bus.PENABLE, in_win && (c > win_setup));
    chk("paddr",   bus.PADDR,   e_paddr);
    chk("pwrite",  bus.PWRITE,  e_pwrite);
    chk("pwdata",  bus.PWDATA,  e_pwdata);
    chk("pstrb",   bus.PSTRB,   e_pstrb);
    chk("pprot",   bus.PPROT,   e_pprot);
    if (rq.size() > 0 && rq[0].cyc == c) begin
      chk("rsp_valid", bus.rsp_valid, 1'b1);
      chk("rsp_err",   bus.rsp_err,   rq[0].err);
      chk("rsp_rdata", bus.rsp_rdata, rq[0].rdata);
      shown_rd = rq[0].rdata;
      void'(rq.pop_front());
    end else begin
      chk("rsp_idle",  bus.rsp_valid, 1'b0);
      chk("rdata_hold", bus.rsp_rdata, shown_rd);
    end
  endtask

  task automatic drive_slaves(input int c);
    for (int i = 0; i < int'(NS); i++) begin
      bus.PREADY[i]           = 1'($urandom);
      bus.PSLVERR[i]          = 1'($urandom);
      bus.PRDATA[i*DW +: DW]  = $urandom;
    end
    if (win_on && c > win_setup && c <= win_done) begin
      bus.PREADY[cur_idx] = (c == win_done);
      if (c == win_done) begin
        bus.PSLVERR[cur_idx]          = cur.err;
        bus.PRDATA[cur_idx*DW +: DW]  = cur.rdata;
      end
    end
  endtask

  task automatic accept(input int t);
    int unsigned region;
    region = nxt.addr >> WIN;
    if (region < NS) begin
      win_on    = 1'b1;
      win_setup = t + 1;
      win_done  = t + 2 + int'(nxt.waits);
      win_sel   = NS'(1) << region;
      cur       = nxt;
      cur_idx   = region;
      e_paddr   = nxt.addr;
      e_pwrite  = nxt.wr;
      e_pwdata  = nxt.wdata;
      e_pstrb   = nxt.wr ? nxt.strb : '0;
      e_pprot   = nxt.prot;
      if (!nxt.wr) last_rd = nxt.rdata;
      rq.push_back('{cyc: win_done + 1, err: nxt.err, rdata: last_rd});
      free_at   = win_done;
    end else begin
      win_on  = 1'b0;
      last_rd = '0;
      rq.push_back('{cyc: t + 2, err: 1'b1, rdata: '0});
      free_at = t + 2;
    end
    pend = 1'b0;
  endtask

  task automatic step(input int c);
    logic exp_ready;
    check_cycle(c);
    drive_slaves(c);
    if (!pend) begin
      if (dir_i < int'(ND)) begin
        nxt = dirs[dir_i]; dir_i++; pend = 1'b1;
      end else if (n_rand < int'(NR) && $urandom_range(3) != 0) begin
        nxt = rand_txn(); n_rand++; pend = 1'b1;
      end
    end
    bus.req_valid = pend;
    bus.req_write = pend ? nxt.wr    : 1'($urandom);
    bus.req_addr  = pend ? nxt.addr  : $urandom;
    bus.req_wdata = pend ? nxt.wdata : $urandom;
    bus.req_strb  = pend ? nxt.strb  : SB'($urandom);
    bus.req_prot  = pend ? nxt.prot  : 3'($urandom);
    #1;
    exp_ready = (c >= free_at);
    chk("req_ready", bus.req_ready, exp_ready);
    if (pend && exp_ready) accept(c);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_psel"},    bus.PSEL,      '0);
    chk({pfx, "_penable"}, bus.PENABLE,   1'b0);
    chk({pfx, "_pwrite"},  bus.PWRITE,    1'b0);
    chk({pfx, "_paddr"},   bus.PADDR,     '0);
    chk({pfx, "_pwdata"},  bus.PWDATA,    '0);
    chk({pfx, "_pstrb"},   bus.PSTRB,     '0);
    chk({pfx, "_pprot"},   bus.PPROT,     '0);
    chk({pfx, "_rvalid"},  bus.rsp_valid, 1'b0);
    chk({pfx, "_rdata"},   bus.rsp_rdata, '0);
    chk({pfx, "_rerr"},    bus.rsp_err,   1'b0);
    chk({pfx, "_ready"},   bus.req_ready, 1'b0);
  endtask

  initial begin
    dirs[0] = '{wr: 1'b1, addr: 32'h0000_1010, wdata: 32'hDEAD_BEEF, rdata: 32'h0,
                strb: 4'hF, prot: 3'd0, waits: 0, err: 1'b0};
    dirs[1] = '{wr: 1'b0, addr: 32'h0000_2004, wdata: 32'h0BAD_F00D, rdata: 32'h1234_5678,
                strb: 4'h9, prot: 3'd1, waits: 3, err: 1'b0};
    dirs[2] = '{wr: 1'b1, addr: 32'h0000_0008, wdata: 32'h1111_1111, rdata: 32'h0,
                strb: 4'h3, prot: 3'd2, waits: 0, err: 1'b0};
    dirs[3] = '{wr: 1'b1, addr: 32'h0000_3FFC, wdata: 32'h2222_2222, rdata: 32'h0,
                strb: 4'hC, prot: 3'd5, waits: 0, err: 1'b0};
    dirs[4] = '{wr: 1'b0, addr: 32'h0000_5000, wdata: 32'h0, rdata: 32'h5555_5555,
                strb: 4'h0, prot: 3'd0, waits: 0, err: 1'b0};
    dirs[5] = '{wr: 1'b0, addr: 32'h0000_0040, wdata: 32'h0, rdata: 32'hA5A5_A5A5,
                strb: 4'h0, prot: 3'd7, waits: 1, err: 1'b1};

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_strb  = '0;   bus.req_prot = '0;
    bus.PREADY    = '0;   bus.PSLVERR   = '0;   bus.PRDATA   = '0;

    repeat (2) @(negedge PCLK);
    #1 chk_reset_outputs("por");
    PRESETn = 1'b1;

    free_at = 0; win_on = 1'b0; win_setup = -1; win_done = -1; win_sel = '0;
    e_paddr = '0; e_pwrite = 1'b0; e_pwdata = '0; e_pstrb = '0; e_pprot = '0;
    last_rd = '0; shown_rd = '0; pend = 1'b0; dir_i = 0; n_rand = 0; cyc = 0; fin = 1'b0;
    cur_idx = 0; cur = dirs[0]; nxt = dirs[0];

    while (!fin) begin
      @(negedge PCLK);
      step(cyc);
      cyc++;
      if (dir_i == int'(ND) && n_rand == int'(NR) && !pend && rq.size() == 0 && cyc > free_at)
        fin = 1'b1;
      else if (cyc > LIMIT) begin
        chk("drain_budget", 1'b0, 1'b1);
        fin = 1'b1;
      end
    end

    // Reset in the middle of a stalled ACCESS.
    @(negedge PCLK);
    bus.PREADY = '0; bus.PSLVERR = '0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_1000;
    bus.req_prot = 3'd3;
    #1 chk("mr_accept", bus.req_ready, 1'b1);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    chk("mr_setup_psel", bus.PSEL, 4'b0010);
    chk("mr_setup_pen",  bus.PENABLE, 1'b0);
    @(negedge PCLK);
    chk("mr_access_pen", bus.PENABLE, 1'b1);
    #1 chk("mr_wait_ready", bus.req_ready, 1'b0);
    #1 PRESETn = 1'b0;
    #1 chk_reset_outputs("mr");
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      chk("mr_no_rsp",  bus.rsp_valid, 1'b0);
      chk("mr_psel",    bus.PSEL, '0);
      chk("mr_penable", bus.PENABLE, 1'b0);
      #1 chk("mr_idle_ready", bus.req_ready, 1'b1);
    end

`ifdef APB_TIMEOUT_EN
    @(negedge PCLK);
    bus.PREADY = '0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0000;
    #1 chk("to_accept", bus.req_ready, 1'b1);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    chk("to_setup_psel", bus.PSEL, 4'b0001);
    for (int k = 0; k < 16; k++) begin
      @(negedge PCLK);
      chk("to_wait_pen",  bus.PENABLE, 1'b1);
      chk("to_wait_psel", bus.PSEL, 4'b0001);
      chk("to_wait_rsp",  bus.rsp_valid, 1'b0);
      #1 chk("to_wait_ready", bus.req_ready, 1'b0);
    end
    @(negedge PCLK);
    chk("to_psel",   bus.PSEL, '0);
    chk("to_pen",    bus.PENABLE, 1'b0);
    chk("to_rvalid", bus.rsp_valid, 1'b1);
    chk("to_rerr",   bus.rsp_err, 1'b1);
    chk("to_rdata",  bus.rsp_rdata, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
